// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: shares NUM_CDB registered writeback ports among NUM_REQ
// functional units using round-robin order with a starvation override and flush.
module cdb_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_CDB      = 2,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                flush_i,
  input  logic [NUM_REQ-1:0]  req_valid_i,
  input  logic [DATA_W-1:0]   req_data_i [NUM_REQ],
  output logic [NUM_REQ-1:0]  req_ready_o,
  output logic [NUM_CDB-1:0]  cdb_valid_o,
  output logic [DATA_W-1:0]   cdb_o [NUM_CDB]
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam int SLOT_W = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]   wait_cnt_reg [NUM_REQ];
  logic [NUM_REQ-1:0] starved;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_CDB-1:0] port_used;
  logic [PTR_W-1:0]   port_src [NUM_CDB];
  logic [NUM_CDB-1:0] cdb_valid_reg;
  logic [DATA_W-1:0]  cdb_data_reg [NUM_CDB];
  logic               arb_en;

  assign arb_en = reset_i & ~flush_i;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_starve
      assign starved[gi] = req_valid_i[gi] && (wait_cnt_reg[gi] == CNT_MAX);
    end
  endgenerate

  // Two scans from rr_ptr: starved requesters first, then everyone else still valid.
  // Grants fill ports in scan order; the last grant made decides the next pointer,
  // which naturally prefers the last pass-2 grant over pass-1 grants.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             cand;
    int               n_used;
    grant       = '0;
    port_used   = '0;
    rr_ptr_next = rr_ptr_reg;
    n_used      = 0;
    sum         = '0;
    idx         = '0;
    cand        = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      port_src[k] = '0;
    end
    if (arb_en) begin
      for (int pass = 0; pass < 2; pass++) begin
        for (int j = 0; j < NUM_REQ; j++) begin
          sum = {1'b0, rr_ptr_reg} + (PTR_W+1)'(j);
          if (sum >= (PTR_W+1)'(NUM_REQ)) begin
            sum = sum - (PTR_W+1)'(NUM_REQ);
          end
          idx  = sum[PTR_W-1:0];
          cand = (pass == 0) ? starved[idx] : (req_valid_i[idx] && !grant[idx]);
          if (cand && (n_used < NUM_CDB)) begin
            grant[idx]                     = 1'b1;
            port_used[SLOT_W'(n_used)]     = 1'b1;
            port_src[SLOT_W'(n_used)]      = idx;
            n_used                         = n_used + 1;
            rr_ptr_next = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
          end
        end
      end
    end
  end

  assign req_ready_o = grant;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cdb_valid_reg <= '0;
      rr_ptr_reg    <= '0;
      for (int k = 0; k < NUM_CDB; k++) begin
        cdb_data_reg[k] <= '0;
      end
    end else if (flush_i) begin
      cdb_valid_reg <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      cdb_valid_reg <= port_used;
      rr_ptr_reg    <= rr_ptr_next;
      // Unused ports keep their last payload; only the valid bit drops.
      for (int k = 0; k < NUM_CDB; k++) begin
        if (port_used[k]) begin
          cdb_data_reg[k] <= req_data_i[port_src[k]];
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_wait
      always_ff @(posedge clk_i) begin
        if (!reset_i || flush_i) begin
          wait_cnt_reg[gi] <= '0;
        end else if (req_valid_i[gi] && !grant[gi]) begin
          if (wait_cnt_reg[gi] != CNT_MAX) begin
            wait_cnt_reg[gi] <= wait_cnt_reg[gi] + 1'b1;
          end
        end else begin
          wait_cnt_reg[gi] <= '0;
        end
      end
    end
  endgenerate

  assign cdb_valid_o = cdb_valid_reg;

  generate
    for (genvar gi = 0; gi < NUM_CDB; gi++) begin : g_out
      assign cdb_o[gi] = cdb_data_reg[gi];
    end
  endgenerate

endmodule
